// File: rtl/mandelbrot_point_driver.sv
// Host-side driver for the Mandelbrot accelerator: serialises C as nibbles,
// strobes start, then turns the unbounded flag into a bounded escape count.
module mandelbrot_point_driver #(
  parameter int ITER_W      = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_cr,
  input  logic [31:0]       req_ci,
  input  logic [ITER_W-1:0] req_max_iter,
  output logic              acc_start,
  output logic [3:0]        acc_cr_nib,
  output logic [3:0]        acc_ci_nib,
  input  logic              acc_unbounded,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ITER_W-1:0] rsp_iter,
  output logic              rsp_escaped,
  output logic              busy
);

  localparam int TW   = ITER_W + 2;
  localparam int SKIP = 1 + SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ITER,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [27:0]       cr_sh, ci_sh;
  logic [ITER_W-1:0] max_q;
  logic [2:0]        k_q;
  logic [TW-1:0]     t_q;

  logic [ITER_W-1:0] n_cur;
  logic              flag_ok;
  logic              hit_esc;
  logic              hit_cap;

  logic              req_ready_d;
  logic              busy_d;
  logic              acc_start_d;
  logic [3:0]        cr_nib_d, ci_nib_d;
  logic              rsp_valid_d;
  logic [ITER_W-1:0] rsp_iter_d;
  logic              rsp_esc_d;

  // The flag lags Z by 1+SYNC_STAGES cycles; before that it is stale.
  assign n_cur   = t_q[ITER_W-1:0] - ITER_W'(SKIP);
  assign flag_ok = (t_q >= TW'(SKIP));
  assign hit_esc = flag_ok & acc_unbounded;
  assign hit_cap = flag_ok & (n_cur == max_q - ITER_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_LOAD;
      S_LOAD:  if (k_q == 3'd7) state_d = S_START;
      S_START: state_d = (max_q == '0) ? S_RESP : S_ITER;
      S_ITER:  if (hit_esc | hit_cap) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    acc_start_d = (state_d == S_START);
    rsp_valid_d = (state_d == S_RESP);
    cr_nib_d    = 4'd0;
    ci_nib_d    = 4'd0;
    if (state_d == S_LOAD) begin
      if (state_q == S_IDLE) begin
        cr_nib_d = req_cr[3:0];
        ci_nib_d = req_ci[3:0];
      end else begin
        cr_nib_d = cr_sh[3:0];
        ci_nib_d = ci_sh[3:0];
      end
    end
    rsp_iter_d = rsp_iter;
    rsp_esc_d  = rsp_escaped;
    unique case (1'b1)
      (state_q == S_START) && (state_d == S_RESP): begin
        rsp_iter_d = '0;
        rsp_esc_d  = 1'b0;
      end
      (state_q == S_ITER) && hit_esc: begin
        rsp_iter_d = n_cur;
        rsp_esc_d  = 1'b1;
      end
      (state_q == S_ITER) && hit_cap && !hit_esc: begin
        rsp_iter_d = max_q;
        rsp_esc_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      acc_start   <= 1'b0;
      acc_cr_nib  <= 4'd0;
      acc_ci_nib  <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_iter    <= '0;
      rsp_escaped <= 1'b0;
      cr_sh       <= '0;
      ci_sh       <= '0;
      max_q       <= '0;
      k_q         <= 3'd0;
      t_q         <= '0;
    end else begin
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      acc_start   <= acc_start_d;
      acc_cr_nib  <= cr_nib_d;
      acc_ci_nib  <= ci_nib_d;
      rsp_valid   <= rsp_valid_d;
      rsp_iter    <= rsp_iter_d;
      rsp_escaped <= rsp_esc_d;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cr_sh <= req_cr[31:4];
            ci_sh <= req_ci[31:4];
            max_q <= req_max_iter;
            k_q   <= 3'd0;
          end
        end
        S_LOAD: begin
          cr_sh <= cr_sh >> 4;
          ci_sh <= ci_sh >> 4;
          k_q   <= k_q + 3'd1;
        end
        S_START: t_q <= '0;
        S_ITER:  t_q <= t_q + TW'(1);
        default: ;
      endcase
    end
  end

endmodule
